// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for alu_multicycle and its iterative multiply/divide
// datapath: opcode constants, controller state encoding, multiply/divide mode
// encoding and the decode helpers that pick the multicycle opcodes out.
package alu_pkg;

  localparam logic [5:0] OP_AND   = 6'h00;
  localparam logic [5:0] OP_OR    = 6'h01;
  localparam logic [5:0] OP_ADD   = 6'h02;
  localparam logic [5:0] OP_ADD2  = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SUB   = 6'h06;
  localparam logic [5:0] OP_SLT   = 6'h07;
  localparam logic [5:0] OP_SLTU  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h09;
  localparam logic [5:0] OP_SLL1  = 6'h0A;
  localparam logic [5:0] OP_SLL2  = 6'h0B;
  localparam logic [5:0] OP_SLL8  = 6'h0C;
  localparam logic [5:0] OP_SRL1  = 6'h0D;
  localparam logic [5:0] OP_SRL2  = 6'h0E;
  localparam logic [5:0] OP_SRL8  = 6'h0F;
  localparam logic [5:0] OP_SRA1  = 6'h10;
  localparam logic [5:0] OP_SRA2  = 6'h11;
  localparam logic [5:0] OP_SRA8  = 6'h12;
  localparam logic [5:0] OP_MULTU = 6'h13;
  localparam logic [5:0] OP_ADJ   = 6'h14;
  localparam logic [5:0] OP_MULT  = 6'h15;
  localparam logic [5:0] OP_DIVU  = 6'h16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2
  } md_mode_t;

  function automatic logic is_multicycle(input logic [5:0] op);
    return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU);
  endfunction

  function automatic md_mode_t md_mode(input logic [5:0] op);
    md_mode_t m;
    case (op)
      OP_MULT: m = MD_MULT;
      OP_DIVU: m = MD_DIVU;
      default: m = MD_MULTU;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter
// Iterative multiply/divide datapath, one bit per cycle for WIDTH cycles.
//   MULTU : unsigned shift-add multiply, {o_hi,o_lo} = s*t
//   MULT  : multiply of magnitudes, 2*WIDTH-bit negate when signs differ
//   DIVU  : restoring division, o_lo = s/t, o_hi = s%t
//           (t==0 falls out naturally as quotient all ones, remainder s)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        load operands and begin (one-cycle pulse)
//   i_mode         operation mode
//   i_s, i_t       operands (sampled with i_start)
//   o_done         high during the final iteration cycle
//   o_lo, o_hi     final result, valid while o_done is high
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  md_mode_t         i_mode,
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_t,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_div;
  logic               r_neg;
  logic [WIDTH-1:0]   r_op;   // multiplicand or divisor
  logic [WIDTH-1:0]   r_lo;   // multiplier bits / dividend-quotient shift reg
  logic [WIDTH-1:0]   r_hi;   // product high accumulator / partial remainder

  logic [WIDTH-1:0]   w_s_mag;
  logic [WIDTH-1:0]   w_t_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [2*WIDTH-1:0] w_raw;
  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_s_mag = i_s;
    w_t_mag = i_t;
    if (i_mode == MD_MULT) begin
      if (i_s[WIDTH-1]) w_s_mag = '0 - i_s;
      if (i_t[WIDTH-1]) w_t_mag = '0 - i_t;
    end
  end

  assign w_sum   = {1'b0, r_hi} + {1'b0, r_op};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_op});
  // When w_ge holds the true difference is below the divisor, so the
  // WIDTH-bit wrap-around subtraction is exact.
  assign w_sub   = w_shift[WIDTH-1:0] - r_op;

  always_comb begin
    w_lo_nxt = r_lo;
    w_hi_nxt = r_hi;
    if (r_div) begin
      w_hi_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else if (r_lo[0]) begin
      {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[WIDTH-1:1]};
    end else begin
      {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
    end
  end

  assign w_raw  = {w_hi_nxt, w_lo_nxt};
  assign w_prod = r_neg ? ('0 - w_raw) : w_raw;
  assign o_lo   = w_prod[WIDTH-1:0];
  assign o_hi   = w_prod[2*WIDTH-1:WIDTH];
  assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_neg  <= 1'b0;
      r_op   <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_div  <= (i_mode == MD_DIVU);
      r_neg  <= (i_mode == MD_MULT) && (i_s[WIDTH-1] ^ i_t[WIDTH-1]);
      r_op   <= w_t_mag;
      r_lo   <= w_s_mag;
      r_hi   <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + CW'(1);
      r_lo  <= w_lo_nxt;
      r_hi  <= w_hi_nxt;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle
// Valid/ready ALU with single-cycle logic/arithmetic/shift ops and iterative
// 32-cycle (WIDTH-cycle) multiply and divide via alu_muldiv_iter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ctrl[5:0]             operation select
//   a, b [WIDTH-1:0]      operands s, t
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   r, r2 [WIDTH-1:0]     result low word / quotient, high word / remainder
//   z                     r == 0
//   err                   invalid opcode or divide by zero
//   out_valid / out_ready result handshake; outputs held until retired
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r2,
  output logic             z,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [WIDTH-1:0] ADJ_K = WIDTH'(100);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_multi;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_sc_r;
  logic             w_sc_err;

  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_r2;
  logic             r_z;
  logic             r_err;
  logic             r_div0;

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_multi    = is_multicycle(ctrl);
  assign w_md_start = w_accept && w_multi;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_md_start),
    .i_mode  (md_mode(ctrl)),
    .i_s     (a),
    .i_t     (b),
    .o_done  (w_md_done),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi)
  );

  always_comb begin
    w_sc_r   = '0;
    w_sc_err = 1'b0;
    case (ctrl)
      OP_AND:           w_sc_r = a & b;
      OP_OR:            w_sc_r = a | b;
      OP_ADD, OP_ADD2:  w_sc_r = a + b;
      OP_XOR:           w_sc_r = a ^ b;
      OP_SUB:           w_sc_r = a - b;
      OP_SLT:           w_sc_r[0] = ($signed(a) < $signed(b));
      OP_SLTU:          w_sc_r[0] = (a < b);
      OP_LUI:           w_sc_r = b << (WIDTH / 2);
      OP_SLL1:          w_sc_r = a << 1;
      OP_SLL2:          w_sc_r = a << 2;
      OP_SLL8:          w_sc_r = a << 8;
      OP_SRL1:          w_sc_r = a >> 1;
      OP_SRL2:          w_sc_r = a >> 2;
      OP_SRL8:          w_sc_r = a >> 8;
      OP_SRA1:          w_sc_r = $signed(a) >>> 1;
      OP_SRA2:          w_sc_r = $signed(a) >>> 2;
      OP_SRA8:          w_sc_r = $signed(a) >>> 8;
      OP_ADJ:           w_sc_r = (a > b) ? (a - ADJ_K) : (a + ADJ_K);
      OP_MULTU, OP_MULT, OP_DIVU: ;
      default:          w_sc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = w_multi ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_md_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only load on accept (single-cycle) or on the final
  // iteration, so they hold naturally through DONE backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r    <= '0;
      r_r2   <= '0;
      r_z    <= 1'b0;
      r_err  <= 1'b0;
      r_div0 <= 1'b0;
    end else begin
      if (w_accept && !w_multi) begin
        r_r   <= w_sc_r;
        r_r2  <= '0;
        r_z   <= (w_sc_r == '0);
        r_err <= w_sc_err;
      end
      if (w_md_start) r_div0 <= (ctrl == OP_DIVU) && (b == '0);
      if ((r_state == ST_BUSY) && w_md_done) begin
        r_r   <= w_md_lo;
        r_r2  <= w_md_hi;
        r_z   <= (w_md_lo == '0);
        r_err <= r_div0;
      end
    end
  end

  assign r   = r_r;
  assign r2  = r_r2;
  assign z   = r_z;
  assign err = r_err;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width in bits; legal values are even and ≥16.
REQ-002 SHALL have port clk  input  1  meaning the single clock, with all state on the rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning reset; reset is asynchronous and active-low.
REQ-004 SHALL have port ctrl  input  6  meaning operation select.
REQ-005 SHALL have port a  input  WIDTH  meaning operand s.
REQ-006 SHALL have port b  input  WIDTH  meaning operand t.
REQ-007 SHALL have port in_valid  input  1  meaning the request (ctrl, a, b) is valid.
REQ-008 SHALL have port in_ready  output  1  meaning the block can accept a request.
REQ-009 SHALL have port r  output  WIDTH  meaning result low word, or quotient.
REQ-010 SHALL have port r2  output  WIDTH  meaning result high word, or remainder.
REQ-011 SHALL have port z  output  1  meaning r equals 0.
REQ-012 SHALL have port err  output  1  meaning invalid opcode or divide-by-zero.
REQ-013 SHALL have port out_valid  output  1  meaning r, r2, z and err are valid.
REQ-014 SHALL have port out_ready  input  1  meaning the consumer accepts the result.

Function
REQ-015 SHALL implement a three-state controller:
- IDLE -> BUSY on accept of a multicycle op.
- IDLE -> DONE on accept of a single-cycle op.
- BUSY -> DONE when the iteration counter reaches WIDTH.
- DONE -> IDLE on out_ready.
REQ-016 SHALL drive in_ready = (state==IDLE); a request is accepted when in_valid && in_ready, and ctrl/a/b are captured at that edge.
REQ-017 SHALL ignore in_valid in BUSY and DONE; no request is queued.
REQ-018 SHALL give single-cycle ops a latency of 1: out_valid rises on the edge after the accept.
- 0x0 AND, 0x1 OR, 0x2/0x3 ADD, 0x4 XOR, 0x6 SUB, all modulo 2^WIDTH.
- 0x7 signed SLT, 0x8 unsigned SLT.
- 0x9 t<<(WIDTH/2).
- 0xA/B/C SLL by 1/2/8; 0xD/E/F SRL by 1/2/8; 0x10/11/12 SRA by 1/2/8.
- 0x14: r = (s>t unsigned) ? s-100 : s+100.
- r2 = 0 for all of these.
REQ-019 SHALL implement 0x13 MULTU with an iterative shift-add, 1 bit per cycle, producing {r2,r} = unsigned 2*WIDTH-bit product; out_valid rises WIDTH+1 cycles after accept.
REQ-020 SHALL implement 0x15 MULT (signed) as a multiply of magnitudes followed by a conditional 2*WIDTH-bit negate; same latency as MULTU; {r2,r} = signed product.
REQ-021 SHALL implement 0x16 DIVU as restoring division with r = s/t and r2 = s%t; latency WIDTH+1.
REQ-022 SHALL, on DIVU with t==0, return r = all ones, r2 = s, err = 1, with the same latency as a normal DIVU.
REQ-023 SHALL, for any other ctrl value, return r = 0, r2 = 0, z = 1, err = 1 with latency 1.
REQ-024 SHALL compute z from the final r only, never from r2.
REQ-025 SHALL hold r, r2, z and err stable while out_valid=1 && out_ready=0; the result is retired on the edge where out_valid && out_ready.
REQ-026 SHALL keep out_valid low in IDLE and BUSY; r, r2, z and err are don't-care while out_valid=0.
REQ-027 SHALL accept a new request at the earliest one cycle after the retire edge, because in_ready rises in IDLE.

Reset
REQ-028 SHALL, on rst_n low, immediately force:
- state = IDLE, counter = 0;
- r = 0, r2 = 0, z = 0, err = 0, out_valid = 0;
- in_ready = 1 while in reset.
REQ-029 SHALL abandon any in-flight BUSY operation on reset without emitting a result.
REQ-030 SHALL leave reset deassertion unsynchronised inside the block; release synchronisation is the integrator's responsibility.

Structure
REQ-031 SHALL define opcode constants 0x0..0x16, the state encoding, and the multicycle-op decode function in shared package alu_pkg.
REQ-032 SHALL place the iterative multiply/divide datapath (accumulator, shift registers, counter, sign fix-up) in a single sub-module alu_muldiv_iter with start/done signalling; the controller and single-cycle ops stay in alu_multicycle.

Verification
REQ-033 SHALL cover: ADD a=0xFFFFFFFF b=1 (WIDTH=32) -> out_valid on the next edge, r=0, z=1, r2=0, err=0.
REQ-034 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> r=0x00000001, r2=0xFFFFFFFE, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-035 SHALL cover: MULT a=-3 b=7 -> {r2,r} = -21, i.e. r=0xFFFFFFEB and r2=0xFFFFFFFF; DIVU a=100 b=7 -> r=14, r2=2; DIVU a=5 b=0 -> r=0xFFFFFFFF, r2=5, err=1.
REQ-036 SHALL cover backpressure: out_ready held 0 for 10 cycles after a result -> outputs unchanged, a second in_valid is not accepted; the retire is followed by in_ready=1 on the next cycle.
REQ-037 SHALL cover reset mid-operation: rst_n pulsed low 10 cycles into MULTU -> out_valid never rises for that op, and a subsequent AND a=0xF0 b=0x3C -> r=0x30.
REQ-038 SHALL cover: ctrl=0x3F -> r=0, z=1, err=1, latency 1; the bench shall also rerun REQ-033 and REQ-035 with WIDTH=16.
